// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: RV32I load/store unit driving a request/valid data memory port.
// One core load/store becomes a single memory transaction; the core is stalled
// through busy until done pulses.
// Optional: define LSU_TIMEOUT_EN to abort a load with fault=1 after TIMEOUT
// WAIT cycles without mem_valid.
module lsu_mem_initiator #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       st_data,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [31:0]       ld_data,
    output logic              mem_request,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_w_data,
    output logic [3:0]        mem_masking,
    output logic              mem_we_re,
    input  logic              mem_valid,
    input  logic [31:0]       mem_r_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state;
    logic        op_store;
    logic [2:0]  op_funct3;
    logic [1:0]  op_lane;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    logic        illegal_c;
    logic        misaligned_c;
    logic [3:0]  st_mask_c;
    logic [31:0] st_wdata_c;
    logic [31:0] lane_c;
    logic [31:0] ld_ext_c;

    // Address bits above the word index and the timeout parameter may be unused.
    logic unused_bits;
    assign unused_bits = ^{addr[31:ADDR_W+2], 32'(TIMEOUT)};

    // Decode legality and alignment of the incoming op.
    always_comb begin
        illegal_c    = 1'b0;
        misaligned_c = 1'b0;
        if (is_store) begin
            illegal_c = (funct3[2] == 1'b1) || (funct3[1:0] == 2'b11);
        end else begin
            illegal_c = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        end
        if (funct3[1:0] == 2'b01) begin
            misaligned_c = addr[0];
        end else if (funct3[1:0] == 2'b10) begin
            misaligned_c = (addr[1:0] != 2'b00);
        end
    end

    // Store byte mask and lane-replicated write data.
    always_comb begin
        st_mask_c  = 4'b0000;
        st_wdata_c = 32'h0;
        case (funct3[1:0])
            2'b00: begin
                st_mask_c  = 4'(4'b0001 << addr[1:0]);
                st_wdata_c = {4{st_data[7:0]}};
            end
            2'b01: begin
                st_mask_c  = 4'(4'b0011 << addr[1:0]);
                st_wdata_c = {2{st_data[15:0]}};
            end
            default: begin
                st_mask_c  = 4'b1111;
                st_wdata_c = st_data;
            end
        endcase
    end

    // Shift the addressed lane down and extend per funct3.
    always_comb begin
        lane_c   = mem_r_data >> {op_lane, 3'b000};
        ld_ext_c = mem_r_data;
        case (op_funct3)
            3'b000:  ld_ext_c = {{24{lane_c[7]}}, lane_c[7:0]};
            3'b001:  ld_ext_c = {{16{lane_c[15]}}, lane_c[15:0]};
            3'b100:  ld_ext_c = {24'h0, lane_c[7:0]};
            3'b101:  ld_ext_c = {16'h0, lane_c[15:0]};
            default: ld_ext_c = mem_r_data;
        endcase
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_store    <= 1'b0;
            op_funct3   <= 3'b000;
            op_lane     <= 2'b00;
            busy        <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
            ld_data     <= 32'h0;
            mem_request <= 1'b0;
            mem_address <= '0;
            mem_w_data  <= 32'h0;
            mem_masking <= 4'b0000;
            mem_we_re   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            done        <= 1'b0;
            mem_request <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_store  <= is_store;
                        op_funct3 <= funct3;
                        op_lane   <= addr[1:0];
                        busy      <= 1'b1;
                        if (illegal_c || misaligned_c) begin
                            // Rejected ops complete without touching memory.
                            state   <= S_RESP;
                            done    <= 1'b1;
                            fault   <= 1'b1;
                            ld_data <= 32'h0;
                        end else begin
                            state       <= S_ISSUE;
                            mem_request <= 1'b1;
                            mem_we_re   <= is_store;
                            mem_address <= addr[ADDR_W+1:2];
                            mem_masking <= is_store ? st_mask_c : 4'b0000;
                            mem_w_data  <= is_store ? st_wdata_c : 32'h0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (op_store) begin
                        state <= S_RESP;
                        done  <= 1'b1;
                        fault <= 1'b0;
                    end else begin
                        state <= S_WAIT;
`ifdef LSU_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (mem_valid) begin
                        state   <= S_RESP;
                        done    <= 1'b1;
                        fault   <= 1'b0;
                        ld_data <= ld_ext_c;
`ifdef LSU_TIMEOUT_EN
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // TIMEOUT-th idle WAIT cycle: give up on the load.
                        state   <= S_RESP;
                        done    <= 1'b1;
                        fault   <= 1'b1;
                        ld_data <= 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    fault <= 1'b0;
                end
            endcase
        end
    end

endmodule
